// File: rtl/tow_match_controller.sv
// Tug-of-war match referee: countdown, play, round hold and match end sequencing,
// round scoring and difficulty latching for the light-field datapath.
module tow_match_controller #(
    parameter int ROUNDS_TO_WIN   = 3,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int HOLD_TICKS      = 2,
    parameter int CNT_W           = 4,
    parameter int SCORE_W         = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CE,
    input  logic               start,
    input  logic               abort,
    input  logic               win_l,
    input  logic               win_r,
    input  logic [8:0]         diff_sel,
    output logic               play_en,
    output logic               field_clr,
    output logic [8:0]         diff_q,
    output logic [CNT_W-1:0]   countdown,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               match_over,
    output logic [1:0]         winner,
    output logic [2:0]         state
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_ROUND_END = 3'd3,
        S_MATCH_END = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   CD_LD   = CNT_W'(COUNTDOWN_TICKS);
    localparam logic [CNT_W-1:0]   HOLD_LD = CNT_W'(HOLD_TICKS);
    localparam logic [SCORE_W-1:0] WIN_SC  = SCORE_W'(ROUNDS_TO_WIN);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
    logic [1:0]         win_q, win_d;
    logic [8:0]         diff_d;
    logic               fc_q, fc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sl_q    <= '0;
            sr_q    <= '0;
            win_q   <= 2'b00;
            diff_q  <= '0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            win_q   <= win_d;
            diff_q  <= diff_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        win_d   = win_q;
        diff_d  = diff_q;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sl_d    = '0;
            sr_d    = '0;
            win_d   = 2'b00;
        end else begin
            case (state_q)
                S_IDLE, S_MATCH_END: begin
                    if (start) begin
                        diff_d  = diff_sel;
                        sl_d    = '0;
                        sr_d    = '0;
                        win_d   = 2'b00;
                        cnt_d   = CD_LD;
                        state_d = S_COUNTDOWN;
                    end
                end
                S_COUNTDOWN: begin
                    if (CE && cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == 1) state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    // A simultaneous win on both sides is a tie: hold, no score.
                    if (win_l && !win_r) begin
                        sl_d = sl_q + 1'b1;
                        if (sl_d == WIN_SC) begin
                            state_d = S_MATCH_END;
                            win_d   = 2'b10;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_ROUND_END;
                            cnt_d   = HOLD_LD;
                        end
                    end else if (win_r && !win_l) begin
                        sr_d = sr_q + 1'b1;
                        if (sr_d == WIN_SC) begin
                            state_d = S_MATCH_END;
                            win_d   = 2'b01;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_ROUND_END;
                            cnt_d   = HOLD_LD;
                        end
                    end else if (win_l && win_r) begin
                        state_d = S_ROUND_END;
                        cnt_d   = HOLD_LD;
                    end
                end
                S_ROUND_END: begin
                    if (CE) begin
                        if (cnt_q <= 1) begin
                            cnt_d   = CD_LD;
                            state_d = S_COUNTDOWN;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Suppressed when the previous clk already pulsed, so an abort right
        // after entering COUNTDOWN cannot produce a two-clk clear.
        fc_d = (state_d != state_q) && (state_d == S_COUNTDOWN || state_d == S_IDLE) && !fc_q;
    end

    assign play_en    = (state_q == S_PLAY);
    assign match_over = (state_q == S_MATCH_END);
    assign countdown  = (state_q == S_COUNTDOWN) ? cnt_q : '0;
    assign field_clr  = fc_q;
    assign score_l    = sl_q;
    assign score_r    = sr_q;
    assign winner     = win_q;
    assign state      = state_q;
endmodule

// File: doc/tow_match_controller.md
Name: tow_match_controller

Overview:
Match referee for the tug-of-war game. It runs a best-of-N match: countdown, play, round hold, match end. It gates when player and computer moves are accepted, clears the light field between rounds, and keeps the round scores. It also latches the computer difficulty word at match start. It sits between the input conditioning (synchronizer and edge detectors) and the light-field datapath, and is clocked on the system clock with the divided CE tick.

Parameters:
ROUNDS_TO_WIN, 3, round wins needed to take the match (1..15)
COUNTDOWN_TICKS, 3, CE ticks spent in COUNTDOWN before play opens (1..(2**CNT_W)-1)
HOLD_TICKS, 2, CE ticks spent in ROUND_END before the next countdown (1..(2**CNT_W)-1)
CNT_W, 4, width of the tick counter and countdown output
SCORE_W, 4, width of the score counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
CE  in  1  one-clk game tick enable
start  in  1  one-clk pulse (edge-detected); starts or restarts a match
abort  in  1  one-clk pulse; returns to IDLE
win_l  in  1  one-clk pulse; left player has won the current round
win_r  in  1  one-clk pulse; computer (right) has won the current round
diff_sel  in  9  difficulty word from switches
play_en  out  1  high only in PLAY; the datapath gates all moves with it
field_clr  out  1  one-clk pulse; resets the light field to center
diff_q  out  9  difficulty word latched at match start
countdown  out  CNT_W  ticks remaining; nonzero only in COUNTDOWN
score_l  out  SCORE_W  left round wins
score_r  out  SCORE_W  right round wins
match_over  out  1  high in MATCH_END
winner  out  2  00 none, 10 left, 01 right; held until the next start, abort or reset
state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, ROUND_END=3, MATCH_END=4

Behaviour:
- Reset (async, active-high): state IDLE; every output and internal counter 0, including diff_q.
- All state changes occur on posedge clk. Changes marked "on CE" only occur on clk edges where CE=1.
- field_clr: registered. It is high for exactly the one clk that follows any transition into COUNTDOWN or IDLE. It is never high for two consecutive clks.

IDLE
- play_en=0.
- On start: latch diff_q<=diff_sel; clear scores and winner; tick counter <= COUNTDOWN_TICKS; go to COUNTDOWN.

COUNTDOWN
- countdown = tick counter.
- On CE: decrement the counter.
- When the counter is 1 on a CE: the counter becomes 0 and the state goes to PLAY.
- Result: exactly COUNTDOWN_TICKS CE ticks are spent in COUNTDOWN.

PLAY
- play_en=1; countdown=0.
- win_l alone:
  - score_l+1 == ROUNDS_TO_WIN: score_l increments, winner=10, go to MATCH_END.
  - otherwise: score_l increments, go to ROUND_END.
- win_r alone: same rules mirrored onto score_r, with winner=01.
- win_l and win_r in the same clk: a tie. No score change; go to ROUND_END.

ROUND_END
- play_en=0 from the first clk of the state.
- Tick counter is loaded with HOLD_TICKS on entry and decrements on CE.
- When the counter is 1 on a CE: reload COUNTDOWN_TICKS and go to COUNTDOWN.

MATCH_END
- match_over=1; scores and winner hold.
- On start: latch diff_q, clear scores and winner, go to COUNTDOWN.

Input handling
- win_l and win_r are ignored outside PLAY.
- start is ignored in COUNTDOWN, PLAY and ROUND_END.

abort
- From any state other than IDLE: go to IDLE; clear scores, winner and counter; field_clr pulses.
- abort has priority over start, win_l and win_r in the same clk.
- abort in IDLE: no effect, no field_clr.

Counters
- Scores never wrap: they saturate at ROUNDS_TO_WIN because the match ends on reaching it.
- Tick counters are unsigned and never underflow.

Reset mid-operation
- An async reset returns the block to IDLE immediately, from any state.
- No field_clr pulse is issued on reset; the datapath is reset by the same reset signal.

Test Plan:
- Reset, then start with diff_sel=9'h0A5 and CE every 4 clks → diff_q=0A5; field_clr high exactly 1 clk; countdown reads 3, 2, 1 on successive CE ticks; PLAY (state=2, play_en=1) on the third CE.
- In PLAY, pulse win_l → score_l=1, state=3, play_en=0. After 2 CE ticks → COUNTDOWN, with one field_clr pulse on entry.
- Three left round wins with ROUNDS_TO_WIN=3 → after the third: state=4, match_over=1, winner=10, score_l=3. Further win_l/win_r pulses leave score_l at 3 and score_r unchanged.
- win_l and win_r in the same clk during PLAY → both scores unchanged; state goes to ROUND_END. win_r pulsed during COUNTDOWN → ignored, score_r unchanged.
- abort and win_r in the same clk during PLAY → state=0, scores=0, winner=00, one field_clr pulse.
- Async reset asserted mid-COUNTDOWN, between clk edges → outputs go to 0 before the next clk edge. start with no CE pulses → state remains COUNTDOWN with countdown=3.
